// File: rtl/arb_mux_nto1_if.sv
// Channel-side and output-side handshake bundle for arb_mux_nto1.
interface arb_mux_nto1_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SW    = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SW-1:0]        sel;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready;

    // Producer/consumer side that drives the channels and the downstream ready.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // The mux itself.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/arb_mux_nto1.sv
// N-to-1 arbitrated mux with a single-entry registered output stage.
// Selection is external (MODE 0), round-robin (MODE 1) or fixed lowest-index priority (MODE 2).
module arb_mux_nto1 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned MODE  = 0
) (
    input logic            clk,
    input logic            rst,
    arb_mux_nto1_if.slave  bus
);
    localparam int unsigned SW = $clog2(NCH);

    logic             free;
    logic             cand_valid;
    logic [SW-1:0]    cand;
    logic             fire;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] cand_word;
    int               idx;

    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q;
    logic [SW-1:0]    out_ch_q;
    logic             out_valid_q;

    // Output stage can take a word when empty or when it is being drained this cycle.
    assign free = !out_valid_q || bus.out_ready;

    // Pick the candidate channel according to the selection policy.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        idx        = 0;
        if (MODE == 0) begin
            // sel values >= NCH never match, so they produce no candidate.
            for (int k = 0; k < int'(NCH); k++) begin
                if (bus.sel == SW'(k) && bus.in_valid[k]) begin
                    cand_valid = 1'b1;
                    cand       = SW'(k);
                end
            end
        end else if (MODE == 1) begin
            // Walk offsets downwards so the valid channel nearest rr_ptr is assigned last.
            for (int off = int'(NCH) - 1; off >= 0; off--) begin
                idx = int'(rr_ptr_q) + off;
                if (idx >= int'(NCH)) idx = idx - int'(NCH);
                if (bus.in_valid[idx]) begin
                    cand_valid = 1'b1;
                    cand       = SW'(idx);
                end
            end
        end else begin
            for (int k = int'(NCH) - 1; k >= 0; k--) begin
                if (bus.in_valid[k]) begin
                    cand_valid = 1'b1;
                    cand       = SW'(k);
                end
            end
        end
    end

    // Candidate is only ever set for a valid channel, so a grant is a transfer.
    assign fire = free && cand_valid && !rst;

    // One-hot grant back to the channels.
    always_comb begin
        grant = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            grant[k] = fire && (cand == SW'(k));
        end
    end

    assign cand_word = bus.in_data[cand*WIDTH +: WIDTH];

    // Round-robin pointer moves just past the channel that transferred.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire && MODE == 1) begin
            rr_ptr_d = (cand == SW'(NCH - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Output register: load on transfer, drop valid on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= cand_word;
                out_ch_q    <= cand;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// Bench for arb_mux_nto1: four instances (ext-sel NCH=4, ext-sel NCH=3, round-robin, priority)
// run side by side against a behavioural model, with directed steps followed by random traffic.
module tb_arb_mux_nto1;
    logic clk;
    logic rst;

    // Stimulus per instance (instance 1 uses only the low 3 channels).
    logic [15:0] d[4];
    logic [3:0]  v[4];
    logic [1:0]  s[4];
    logic        ordy[4];

    // Observed outputs per instance.
    logic [3:0]  rdy_o[4];
    logic [3:0]  od_o[4];
    logic [1:0]  oc_o[4];
    logic        ov_o[4];

    // Behavioural model state.
    logic        mv[4];
    logic [3:0]  md[4];
    logic [1:0]  mc[4];
    int          ptr[4];

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb_mux_nto1_if #(.WIDTH(4), .NCH(4)) if0 ();
    arb_mux_nto1_if #(.WIDTH(4), .NCH(3)) if1 ();
    arb_mux_nto1_if #(.WIDTH(4), .NCH(4)) if2 ();
    arb_mux_nto1_if #(.WIDTH(4), .NCH(4)) if3 ();

    assign if0.in_data = d[0];
    assign if0.in_valid = v[0];
    assign if0.sel = s[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_data = d[1][11:0];
    assign if1.in_valid = v[1][2:0];
    assign if1.sel = s[1];
    assign if1.out_ready = ordy[1];
    assign if2.in_data = d[2];
    assign if2.in_valid = v[2];
    assign if2.sel = s[2];
    assign if2.out_ready = ordy[2];
    assign if3.in_data = d[3];
    assign if3.in_valid = v[3];
    assign if3.sel = s[3];
    assign if3.out_ready = ordy[3];

    assign rdy_o[0] = if0.in_ready;
    assign rdy_o[1] = {1'b0, if1.in_ready};
    assign rdy_o[2] = if2.in_ready;
    assign rdy_o[3] = if3.in_ready;
    assign od_o[0] = if0.out_data;
    assign od_o[1] = if1.out_data;
    assign od_o[2] = if2.out_data;
    assign od_o[3] = if3.out_data;
    assign oc_o[0] = if0.out_ch;
    assign oc_o[1] = if1.out_ch;
    assign oc_o[2] = if2.out_ch;
    assign oc_o[3] = if3.out_ch;
    assign ov_o[0] = if0.out_valid;
    assign ov_o[1] = if1.out_valid;
    assign ov_o[2] = if2.out_valid;
    assign ov_o[3] = if3.out_valid;

    arb_mux_nto1 #(.WIDTH(4), .NCH(4), .MODE(0)) u_ext4 (.clk(clk), .rst(rst), .bus(if0.slave));
    arb_mux_nto1 #(.WIDTH(4), .NCH(3), .MODE(0)) u_ext3 (.clk(clk), .rst(rst), .bus(if1.slave));
    arb_mux_nto1 #(.WIDTH(4), .NCH(4), .MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(if2.slave));
    arb_mux_nto1 #(.WIDTH(4), .NCH(4), .MODE(2)) u_pri (.clk(clk), .rst(rst), .bus(if3.slave));

    function automatic int nch_of(input int i);
        return (i == 1) ? 3 : 4;
    endfunction

    function automatic int mode_of(input int i);
        return (i <= 1) ? 0 : i - 1;
    endfunction

    // Expected grant vector from the selection rules, given current model state and inputs.
    function automatic logic [3:0] model_grant(input int i);
        logic [3:0] r;
        int n;
        int k;
        r = 4'b0;
        n = nch_of(i);
        if (rst) return r;
        if (mv[i] && !ordy[i]) return r;
        case (mode_of(i))
            0: begin
                if (int'(s[i]) < n && v[i][s[i]]) r[s[i]] = 1'b1;
            end
            1: begin
                for (int j = 0; j < n; j++) begin
                    k = (ptr[i] + j) % n;
                    if (r == 4'b0 && v[i][k]) r[k] = 1'b1;
                end
            end
            default: begin
                for (int j = 0; j < n; j++) begin
                    if (r == 4'b0 && v[i][j]) r[j] = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every instance with the model, away from the active edge.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_in_ready", i), 16'(rdy_o[i]), 16'(model_grant(i)));
            chk($sformatf("u%0d_out_valid", i), 16'(ov_o[i]), 16'(mv[i]));
            chk($sformatf("u%0d_out_data", i), 16'(od_o[i]), 16'(md[i]));
            chk($sformatf("u%0d_out_ch", i), 16'(oc_o[i]), 16'(mc[i]));
        end
    endtask

    // Advance the model across the rising edge, then let inputs change.
    task automatic tick();
        logic [3:0] g[4];
        int k;
        @(posedge clk);
        for (int i = 0; i < 4; i++) g[i] = model_grant(i);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mv[i] = 1'b0;
                md[i] = 4'h0;
                mc[i] = 2'd0;
                ptr[i] = 0;
            end else if (g[i] != 4'b0) begin
                k = 0;
                for (int j = 0; j < 4; j++) if (g[i][j]) k = j;
                mv[i] = 1'b1;
                md[i] = d[i][k*4 +: 4];
                mc[i] = 2'(k);
                ptr[i] = (k + 1) % nch_of(i);
            end else if (ordy[i]) begin
                mv[i] = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 4'h0;
            mc[i] = 2'd0;
            ptr[i] = 0;
            d[i] = 16'hDCBA;
            v[i] = 4'hF;
            s[i] = 2'd0;
            ordy[i] = 1'b1;
        end
        s[0] = 2'd2;
        s[1] = 2'd3;

        // Reset held for two edges with every channel valid.
        tick();
        sample();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_in_ready_%0d", i), 16'(rdy_o[i]), 16'd0);
            chk($sformatf("rst_out_valid_%0d", i), 16'(ov_o[i]), 16'd0);
            chk($sformatf("rst_out_data_%0d", i), 16'(od_o[i]), 16'd0);
        end
        tick();

        // Release: ext-sel picks channel 2, sel=3 on NCH=3 is dead, RR rotates, priority stalls.
        rst = 1'b0;
        v[3] = 4'b1010;
        for (int t = 0; t < 6; t++) begin
            ordy[3] = (t == 1 || t == 2) ? 1'b0 : 1'b1;
            sample();
            if (t == 0) chk("ext4_grant", 16'(rdy_o[0]), 16'b0100);
            if (t == 1) begin
                chk("ext4_data", 16'(od_o[0]), 16'hC);
                chk("ext4_ch", 16'(oc_o[0]), 16'd2);
                chk("ext4_valid", 16'(ov_o[0]), 16'd1);
            end
            chk("ext3_sel_oob_ready", 16'(rdy_o[1]), 16'd0);
            chk("ext3_sel_oob_valid", 16'(ov_o[1]), 16'd0);
            chk("rr_grant_seq", 16'(rdy_o[2]), 16'(1 << (t % 4)));
            if (t > 0) chk("rr_ch_seq", 16'(oc_o[2]), 16'((t - 1) % 4));
            if (t == 0 || t == 3) chk("pri_grant", 16'(rdy_o[3]), 16'b0010);
            if (t == 1 || t == 2) begin
                chk("pri_stall_ready", 16'(rdy_o[3]), 16'd0);
                chk("pri_stall_data", 16'(od_o[3]), 16'hB);
            end
            tick();
        end

        // Round-robin with channel 1 dropped: pointer sits at 2, so 2,3,0,2.
        v[2] = 4'b1101;
        for (int t = 0; t < 4; t++) begin
            sample();
            chk("rr_skip_seq", 16'(rdy_o[2]), 16'((t == 1) ? 8 : (t == 2) ? 1 : 4));
            tick();
        end

        // Mid-stream reset with a held word and the pointer at 3.
        ordy[2] = 1'b0;
        rst = 1'b1;
        sample();
        chk("mid_rst_ready", 16'(rdy_o[2]), 16'd0);
        chk("mid_rst_held", 16'(ov_o[2]), 16'd1);
        tick();
        rst = 1'b0;
        v[2] = 4'b0110;
        sample();
        chk("mid_post_valid", 16'(ov_o[2]), 16'd0);
        chk("mid_post_grant", 16'(rdy_o[2]), 16'b0010);
        tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 4; i++) begin
                d[i] = 16'($urandom);
                v[i] = 4'($urandom);
                s[i] = 2'($urandom);
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            sample();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arb_mux_nto1.md
Name: arb_mux_nto1

Overview:
- Parametrised successor to the 4-bit 2:1 gate-level select mux used in the carry-select adders.
- Selects one of NCH input channels of WIDTH bits each, using external-select, round-robin or fixed-priority mode.
- Registers the selected word into a single-entry output stage with valid/ready handshakes on both sides.
- Sits between parallel adder result lanes and a shared downstream consumer such as a result bus or checker.

Parameters:
- WIDTH, 4: data bits per channel, minimum 1.
- NCH, 4: number of input channels, 2..16.
- MODE, 0: selection policy. 0 = external sel; 1 = round-robin; 2 = fixed priority, lowest index wins.
- SW, $clog2(NCH): width of sel and out_ch (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (grant); combinational.
- sel  input  SW  channel select, used only when MODE=0.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SW  index of the channel held in out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready=0 in the cycle rst is high.
- Free signal: free = !out_valid | out_ready.
- Grant candidate g per mode:
  - MODE 0: g = sel, qualified by sel < NCH and in_valid[sel]. No candidate when sel >= NCH (non-power-of-2 NCH).
  - MODE 1: first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NCH.
  - MODE 2: lowest k with in_valid[k]=1.
- in_ready[k] = free & candidate exists & (k==g) & !rst. At most one bit is set (one-hot or zero).
- Transfer on channel k when in_valid[k] & in_ready[k]. On the next clk edge:
  - out_data <= in_data[k]; out_ch <= k; out_valid <= 1.
- Latency: an input word appears at out_data exactly 1 cycle after its transfer.
- Output drain: when out_valid & out_ready with no new transfer, out_valid <= 0. out_data and out_ch hold their last value.
- Simultaneous drain and accept: the new word replaces the old in the same cycle. Full throughput is 1 word/cycle with no bubble.
- Stall (out_valid & !out_ready):
  - all in_ready=0; out_data, out_ch and out_valid are held stable.
  - inputs are never dropped or overwritten.
- Round-robin pointer (MODE 1 only): after a transfer from channel k, rr_ptr <= (k+1) mod NCH, with wrap at NCH-1 going to 0. Without a transfer, rr_ptr holds.
- Unused channels: in_valid[k]=0 never gets a grant. in_data of non-granted channels is ignored.
- Reset mid-operation: any held word is discarded (out_valid=0 next cycle) and rr_ptr returns to 0. No transfer completes in a cycle where rst=1.
- All state is updated on clk only; there are no asynchronous paths.

Test Plan:
- Reset: hold rst for 2 cycles with all in_valid=1 and out_ready=1.
  -> out_valid=0, out_data=0, in_ready=0 during reset.
  -> First transfer occurs in the cycle after rst falls.
- MODE 0, NCH=4, WIDTH=4: channels carry 0xA, 0xB, 0xC, 0xD, all valid; sel=2, out_ready=1.
  -> in_ready=4'b0100.
  -> Next cycle out_data=0xC, out_ch=2, out_valid=1.
- MODE 0, NCH=3, sel=3.
  -> in_ready=0 and out_valid stays 0.
- MODE 1, all 4 channels valid continuously, out_ready=1.
  -> Grants cycle 0,1,2,3,0,1 on consecutive cycles.
  -> out_ch follows the same sequence one cycle later with no gaps.
  -> Then drop in_valid[1]: the order skips channel 1 (…,0,2,3,0,…).
- MODE 2, in_valid=4'b1010, out_ready toggling 1,0,0,1.
  -> Channel 1 is granted.
  -> out_data is held stable and in_ready=0 during the two stall cycles.
  -> The next grant is again channel 1 while it stays valid.
- Mid-stream reset (MODE 1): with out_valid=1, rr_ptr=3 and out_ready=0, pulse rst for 1 cycle.
  -> out_valid=0 next cycle.
  -> First post-reset grant goes to the lowest valid channel at or after index 0.
